// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response port between the fetch sequencer
// (master) and the instruction memory (slave). One request is outstanding
// at a time; the response is a single-cycle im_ready pulse carrying im_rdata.
interface fetch_sequencer_if #(
  parameter int unsigned DATA_SIZE = 32
);
  logic                 im_req;
  logic [DATA_SIZE-1:0] im_addr;
  logic                 im_ready;
  logic [DATA_SIZE-1:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ready,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ready,
    output im_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues one instruction-memory request at a time, buffers
// the returned instruction while the pipeline is held, squashes an in-flight
// fetch on a taken jump, and drives the PC-select controls (pc_stall,
// cpu_stall, enable_jump) plus the IF/ID flush.
module fetch_sequencer #(
  parameter int unsigned          DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] NOP_INSTR = DATA_SIZE'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_SIZE-1:0]  pc,
  input  logic                  branch_taken,
  input  logic                  dm_busy,
  input  logic                  load_use,
  fetch_sequencer_if.master     imem,
  output logic [DATA_SIZE-1:0]  instr,
  output logic                  instr_valid,
  output logic                  pc_stall,
  output logic                  cpu_stall,
  output logic                  enable_jump,
  output logic                  flush
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SQUASH = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [DATA_SIZE-1:0] addr_r;
  logic [DATA_SIZE-1:0] instr_r;
  logic                 instr_valid_r;

  logic                 hold_s;
  logic                 jump_s;
  logic                 capture_s;
  logic                 consume_s;
  logic                 im_req_s;
  logic [DATA_SIZE-1:0] im_addr_s;
  logic                 pc_stall_s;
  logic                 enable_jump_s;
  logic                 flush_s;

  // Pipeline hold sources: a data-memory wait freezes everything, a
  // load-use hazard only stops new instructions entering ID.
  assign hold_s = dm_busy | load_use;

  // A jump is taken whenever the pipeline is not frozen by the data memory;
  // load_use never blocks it. IDLE is the post-reset cycle and ignores jumps.
  assign jump_s = branch_taken & ~dm_busy & (state_r != ST_IDLE);

  // Next-state and control-output decode. pc_stall defaults high; it only
  // drops when an instruction is handed to ID or a jump redirects the PC.
  always_comb begin
    state_next_s  = state_r;
    im_req_s      = 1'b0;
    im_addr_s     = addr_r;
    pc_stall_s    = 1'b1;
    enable_jump_s = 1'b0;
    flush_s       = 1'b0;
    capture_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_REQ;
      end

      ST_REQ: begin
        im_req_s  = 1'b1;
        im_addr_s = pc;
        if (jump_s) begin
          state_next_s = ST_SQUASH;
        end else begin
          state_next_s = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Address comes from the latched copy: pc may already be moving.
        im_req_s  = 1'b1;
        im_addr_s = addr_r;
        if (jump_s) begin
          // With the response in hand it is simply dropped; otherwise it
          // still has to be drained before the next request.
          if (imem.im_ready) begin
            state_next_s = ST_REQ;
          end else begin
            state_next_s = ST_SQUASH;
          end
        end else if (imem.im_ready) begin
          capture_s = 1'b1;
          if (!hold_s) begin
            pc_stall_s   = 1'b0;
            state_next_s = ST_REQ;
          end else begin
            state_next_s = ST_HOLD;
          end
        end else begin
          state_next_s = ST_WAIT;
        end
      end

      ST_HOLD: begin
        if (jump_s) begin
          state_next_s = ST_REQ;
        end else if (!hold_s) begin
          pc_stall_s   = 1'b0;
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_HOLD;
        end
      end

      ST_SQUASH: begin
        // Drain the killed response; extra jumps only redirect the PC.
        if (imem.im_ready) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_SQUASH;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // An accepted jump overrides the stall for exactly its own cycle.
    if (jump_s) begin
      enable_jump_s = 1'b1;
      pc_stall_s    = 1'b0;
      flush_s       = 1'b1;
    end else begin
      enable_jump_s = 1'b0;
      flush_s       = 1'b0;
    end
  end

  // An instruction in ID is consumed whenever the PC advances without a jump.
  assign consume_s = ~pc_stall_s & ~jump_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request address latch and ID-facing instruction buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r        <= '0;
      instr_r       <= NOP_INSTR;
      instr_valid_r <= 1'b0;
    end else begin
      if (state_r == ST_REQ) begin
        addr_r <= pc;
      end else begin
        addr_r <= addr_r;
      end

      if (jump_s) begin
        instr_r       <= NOP_INSTR;
        instr_valid_r <= 1'b0;
      end else if (capture_s) begin
        instr_r       <= imem.im_rdata;
        instr_valid_r <= 1'b1;
      end else if (consume_s) begin
        instr_r       <= instr_r;
        instr_valid_r <= 1'b0;
      end else begin
        instr_r       <= instr_r;
        instr_valid_r <= instr_valid_r;
      end
    end
  end

  assign imem.im_req  = im_req_s;
  assign imem.im_addr = im_addr_s;
  assign instr        = instr_r;
  assign instr_valid  = instr_valid_r;
  assign pc_stall     = pc_stall_s;
  assign cpu_stall    = dm_busy;
  assign enable_jump  = enable_jump_s;
  assign flush        = flush_s;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer. Each table row is one
// clock cycle: inputs are driven after the falling edge, outputs are checked
// 1 time unit later (before the next rising edge). instr/instr_valid are the
// values registered by the earlier edges.
module tb_fetch_sequencer;

  localparam int unsigned DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pc;
  logic          branch_taken;
  logic          dm_busy;
  logic          load_use;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          pc_stall;
  logic          cpu_stall;
  logic          enable_jump;
  logic          flush;

  fetch_sequencer_if #(.DATA_SIZE(DW)) imem_if ();

  fetch_sequencer #(.DATA_SIZE(DW), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .branch_taken (branch_taken),
    .dm_busy      (dm_busy),
    .load_use     (load_use),
    .imem         (imem_if),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc_stall     (pc_stall),
    .cpu_stall    (cpu_stall),
    .enable_jump  (enable_jump),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        rdy;
    logic [31:0] rdata;
    logic        br;
    logic        dm;
    logic        lu;
    logic        req;
    logic [31:0] addr;
    logic        pst;
    logic        ej;
    logic        fl;
    logic [31:0] ins;
    logic        vld;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic r, logic [31:0] p, logic rdy, logic [31:0] rd,
                              logic b, logic d, logic l, logic rq, logic [31:0] a,
                              logic ps, logic e, logic f, logic [31:0] i, logic v);
    vec_t t;
    t.rst = r;  t.pc = p;    t.rdy = rdy; t.rdata = rd;
    t.br  = b;  t.dm = d;    t.lu  = l;
    t.req = rq; t.addr = a;  t.pst = ps;  t.ej = e; t.fl = f;
    t.ins = i;  t.vld = v;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic rdy, input logic [31:0] rd,
                       input logic b, input logic d, input logic l);
    rst              = r;
    pc               = p;
    imem_if.im_ready = rdy;
    imem_if.im_rdata = rd;
    branch_taken     = b;
    dm_busy          = d;
    load_use         = l;
  endtask

  initial begin
    int cycles;

    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    //                rst pc           rdy rdata         br   dm   lu   | req  addr         pst  ej   fl   instr         vld
    // Reset, then a single fetch from 0x100 answered two cycles after REQ.
    vecs.push_back(mk(1'b1, 32'h100,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0,    1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h100,  1'b0, 32'h0,        1'b1,1'b0,1'b0, 1'b0,32'h0,    1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h100,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h100,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h100,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h100,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h100,  1'b1, 32'hDEADBEEF, 1'b0,1'b0,1'b0, 1'b1,32'h100,  1'b0,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h104,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h104,  1'b1,1'b0,1'b0, 32'hDEADBEEF, 1'b1));
    // WAIT uses the latched address even if pc wanders; then load_use stall.
    vecs.push_back(mk(1'b0, 32'hBAD0, 1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h104,  1'b1,1'b0,1'b0, 32'hDEADBEEF, 1'b1));
    vecs.push_back(mk(1'b0, 32'h104,  1'b1, 32'hCAFEF00D, 1'b0,1'b0,1'b1, 1'b1,32'h104,  1'b1,1'b0,1'b0, 32'hDEADBEEF, 1'b1));
    vecs.push_back(mk(1'b0, 32'h104,  1'b0, 32'h0,        1'b0,1'b0,1'b1, 1'b0,32'h104,  1'b1,1'b0,1'b0, 32'hCAFEF00D, 1'b1));
    vecs.push_back(mk(1'b0, 32'h104,  1'b0, 32'h0,        1'b0,1'b0,1'b1, 1'b0,32'h104,  1'b1,1'b0,1'b0, 32'hCAFEF00D, 1'b1));
    vecs.push_back(mk(1'b0, 32'h104,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b0,32'h104,  1'b0,1'b0,1'b0, 32'hCAFEF00D, 1'b1));
    vecs.push_back(mk(1'b0, 32'h108,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h108,  1'b1,1'b0,1'b0, 32'hCAFEF00D, 1'b0));
    // Jump during WAIT, squashed response 0x11111111 two cycles later.
    vecs.push_back(mk(1'b0, 32'h108,  1'b0, 32'h0,        1'b1,1'b0,1'b0, 1'b1,32'h108,  1'b0,1'b1,1'b1, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b0, 32'h400,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b0,32'h108,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h400,  1'b1, 32'h11111111, 1'b0,1'b0,1'b0, 1'b0,32'h108,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h400,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h400,  1'b1,1'b0,1'b0, NOP,          1'b0));
    // Jump blocked by dm_busy, accepted when it drops (load_use does not block).
    vecs.push_back(mk(1'b0, 32'h400,  1'b0, 32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h400,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h400,  1'b0, 32'h0,        1'b1,1'b1,1'b1, 1'b1,32'h400,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h400,  1'b0, 32'h0,        1'b1,1'b0,1'b1, 1'b1,32'h400,  1'b0,1'b1,1'b1, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h500,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b0,32'h400,  1'b1,1'b0,1'b0, NOP,          1'b0));
    // Second jump while squashing: redirect, stay until the drain.
    vecs.push_back(mk(1'b0, 32'h500,  1'b0, 32'h0,        1'b1,1'b0,1'b0, 1'b0,32'h400,  1'b0,1'b1,1'b1, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h600,  1'b1, 32'h22222222, 1'b0,1'b0,1'b0, 1'b0,32'h400,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h600,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h600,  1'b1,1'b0,1'b0, NOP,          1'b0));
    // Jump coincident with im_ready: response dropped, straight back to REQ.
    vecs.push_back(mk(1'b0, 32'h600,  1'b1, 32'h33333333, 1'b1,1'b0,1'b0, 1'b1,32'h600,  1'b0,1'b1,1'b1, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h700,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h700,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h700,  1'b1, 32'h44444444, 1'b0,1'b0,1'b0, 1'b1,32'h700,  1'b0,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h704,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h704,  1'b1,1'b0,1'b0, 32'h44444444, 1'b1));
    // Reset mid-WAIT, late responses in IDLE and REQ ignored.
    vecs.push_back(mk(1'b1, 32'h704,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h704,  1'b1,1'b0,1'b0, 32'h44444444, 1'b1));
    vecs.push_back(mk(1'b0, 32'h800,  1'b1, 32'h55555555, 1'b0,1'b0,1'b0, 1'b0,32'h0,    1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h800,  1'b1, 32'h66666666, 1'b0,1'b0,1'b0, 1'b1,32'h800,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h800,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h800,  1'b1,1'b0,1'b0, NOP,          1'b0));
    // Capture under dm_busy into HOLD, jump blocked then accepted out of HOLD.
    vecs.push_back(mk(1'b0, 32'h800,  1'b1, 32'h77777777, 1'b0,1'b1,1'b0, 1'b1,32'h800,  1'b1,1'b0,1'b0, NOP,          1'b0));
    vecs.push_back(mk(1'b0, 32'h800,  1'b0, 32'h0,        1'b1,1'b1,1'b0, 1'b0,32'h800,  1'b1,1'b0,1'b0, 32'h77777777, 1'b1));
    vecs.push_back(mk(1'b0, 32'h800,  1'b0, 32'h0,        1'b1,1'b0,1'b0, 1'b0,32'h800,  1'b0,1'b1,1'b1, 32'h77777777, 1'b1));
    vecs.push_back(mk(1'b0, 32'h900,  1'b0, 32'h0,        1'b0,1'b0,1'b0, 1'b1,32'h900,  1'b1,1'b0,1'b0, NOP,          1'b0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].pc, vecs[i].rdy, vecs[i].rdata, vecs[i].br, vecs[i].dm, vecs[i].lu);
      #1;
      chk("im_req",      i, {31'd0, imem_if.im_req}, {31'd0, vecs[i].req});
      chk("im_addr",     i, imem_if.im_addr,         vecs[i].addr);
      chk("pc_stall",    i, {31'd0, pc_stall},       {31'd0, vecs[i].pst});
      chk("enable_jump", i, {31'd0, enable_jump},    {31'd0, vecs[i].ej});
      chk("flush",       i, {31'd0, flush},          {31'd0, vecs[i].fl});
      chk("cpu_stall",   i, {31'd0, cpu_stall},      {31'd0, vecs[i].dm});
      chk("instr",       i, instr,                   vecs[i].ins);
      chk("instr_valid", i, {31'd0, instr_valid},    {31'd0, vecs[i].vld});
    end

    // Back-to-back fetches: one instruction every two cycles.
    @(negedge clk);
    drive(1'b1, 32'hA00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'hA00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    cycles = 0;
    while (imem_if.im_req !== 1'b1 && cycles < 8) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    chk("req_after_reset", 100, {31'd0, imem_if.im_req}, 32'd1);

    for (int k = 0; k < 4; k++) begin
      chk("b2b_req_addr", 200 + k, imem_if.im_addr, 32'hA00 + 32'(4 * k));
      chk("b2b_req_pst",  200 + k, {31'd0, pc_stall}, 32'd1);
      @(negedge clk);
      imem_if.im_ready = 1'b1;
      imem_if.im_rdata = 32'hA5A5_0000 + 32'(k);
      #1;
      chk("b2b_wait_pst", 200 + k, {31'd0, pc_stall}, 32'd0);
      chk("b2b_wait_req", 200 + k, {31'd0, imem_if.im_req}, 32'd1);
      @(negedge clk);
      imem_if.im_ready = 1'b0;
      pc = 32'hA00 + 32'(4 * (k + 1));
      #1;
      chk("b2b_instr", 200 + k, instr, 32'hA5A5_0000 + 32'(k));
      chk("b2b_valid", 200 + k, {31'd0, instr_valid}, 32'd1);
      chk("b2b_req",   200 + k, {31'd0, imem_if.im_req}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetch for the CPU core and drives the control inputs of the PC-select logic (`pc_stall`, `cpu_stall`, `enable_jump`). It issues one instruction-memory request at a time and waits for the memory response. It buffers the returned instruction while the pipeline is stalled, and squashes an in-flight fetch when EX resolves a taken jump. It sits between the PC register, the instruction memory port, and the ID stage.

## Interface
- `DATA_SIZE`, 32, address/instruction width
- `NOP_INSTR`, 32'h0000_0013, value of `instr` when invalid or flushed
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `pc` in DATA_SIZE: current PC register value
- `im_ready` in 1: instruction memory response valid, one-cycle pulse
- `im_rdata` in DATA_SIZE: instruction data, valid when `im_ready`=1
- `branch_taken` in 1: EX resolved a taken jump/branch this cycle
- `dm_busy` in 1: data memory wait; freezes whole pipeline
- `load_use` in 1: load-use hazard detected in ID
- `im_req` out 1: instruction memory request
- `im_addr` out DATA_SIZE: request address
- `instr` out DATA_SIZE: instruction to ID
- `instr_valid` out 1: `instr` holds a real fetched instruction
- `pc_stall` out 1: hold PC (PC-select input)
- `cpu_stall` out 1: freeze pipeline (PC-select input); equals `dm_busy`
- `enable_jump` out 1: select jump address at PC-select
- `flush` out 1: kill IF/ID contents this cycle

## Operation
- Internal stall: `hold = dm_busy | load_use`.
- A jump is accepted when `branch_taken & ~dm_busy`. `load_use` never blocks a jump.
- States: IDLE, REQ, WAIT, HOLD, SQUASH.
- **IDLE:** entered on reset. Moves to REQ after one cycle. Jumps are ignored.
- **REQ:**
  - `im_req`=1 and `im_addr`=`pc`. The address is also latched into `addr_q`.
  - Next state is WAIT, or SQUASH if a jump is accepted in this cycle.
- **WAIT:**
  - `im_req`=1 and `im_addr`=`addr_q`; the request is held until the response arrives.
  - On `im_ready` with no jump accepted:
    - `instr`←`im_rdata`, `instr_valid`←1.
    - If `hold`=0: `pc_stall`=0 for this cycle, next state REQ.
    - Otherwise: next state HOLD.
  - On a jump accepted without `im_ready`: next state SQUASH.
  - On a jump accepted with `im_ready`: the response is discarded, next state REQ.
- **HOLD:**
  - `im_req`=0 and the buffered `instr` is held.
  - When `hold` drops to 0: `pc_stall`=0 for this cycle, next state REQ.
  - On a jump accepted: next state REQ.
- **SQUASH:**
  - `im_req`=0. Wait for `im_ready`, discard `im_rdata`, then go to REQ.
  - Further accepted jumps stay in SQUASH; the PC is still redirected.
- **Any accepted jump:**
  - `enable_jump`=1, `pc_stall`=0 and `flush`=1 for exactly that cycle.
  - `instr_valid`←0 and `instr`←`NOP_INSTR` on the next edge.
- **Default:** `pc_stall`=1 in every cycle not listed above. `enable_jump`=0 and `flush`=0 outside accepted jumps.
- **Valid clearing:** `instr_valid` drops to 0 on the edge after the instruction is consumed, i.e. in a cycle where `pc_stall`=0 without a jump. The exception is when a new response is captured on that same edge.

## Timing
- Reset state (next edge with `rst`=1):
  - State IDLE, `addr_q`=0, `instr`=`NOP_INSTR`, `instr_valid`=0.
  - Outputs: `im_req`=0, `pc_stall`=1, `enable_jump`=0, `flush`=0.
  - `cpu_stall` follows `dm_busy` combinationally.
- `rst` asserted mid-fetch: return to IDLE immediately. Any later `im_ready` arriving in IDLE or REQ is ignored.
- Control outputs (`im_req`, `im_addr`, `pc_stall`, `enable_jump`, `flush`) are Moore/Mealy combinational from state and inputs. `instr`/`instr_valid` are registered.
- Best-case throughput: one instruction every 2 cycles (REQ→WAIT with `im_ready` in the first WAIT cycle).
- `im_ready` is never expected in the REQ cycle itself.
- At most one outstanding request. A squashed response is always drained before a new REQ.
- `pc` must change only when `pc_stall`=0. The sequencer relies on `addr_q`, not `pc`, after REQ.

## Test plan
- **Reset then single fetch:**
  - Deassert `rst`, pc=0x100, `im_ready` 2 cycles after REQ with 0xDEADBEEF.
  - Required: `im_req` high in REQ+WAIT with `im_addr`=0x100.
  - Required: `pc_stall`=0 for one cycle, then `instr`=0xDEADBEEF with `instr_valid`=1.
- **Stall during response:**
  - `load_use`=1 when `im_ready` arrives, held 3 cycles.
  - Required: HOLD state, `pc_stall`=1 and `instr` stable for 3 cycles, then one `pc_stall`=0 cycle.
- **Jump during WAIT:**
  - `branch_taken` while waiting, `im_ready` 2 cycles later with 0x1111_1111.
  - Required: `enable_jump`=`flush`=1 for one cycle, 0x1111_1111 never appears with `instr_valid`=1.
  - Required: the next REQ uses the new pc.
- **Jump with `dm_busy`=1:**
  - Required: jump ignored, `enable_jump`=0, `cpu_stall`=1.
  - Required: the jump is accepted on the first cycle `dm_busy`=0 while `branch_taken` is still high.
- **Jump coincident with `im_ready`:**
  - Required: response discarded, next state REQ (no SQUASH), `instr_valid`=0.
- **Reset mid-WAIT:**
  - Required: all outputs return to reset values on the next edge.
  - Required: a late `im_ready` does not set `instr_valid`.
